// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcode values, FSM state encoding and RAS default depth.
package pipe_ctrl_pkg;
  localparam logic [3:0] OP_B = 4'hA;
  localparam logic [3:0] OP_CALL = 4'hB;
  localparam logic [3:0] OP_RET = 4'hC;
  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_RET_REDIR = 2'd2;
  localparam int RAS_DEPTH_DEF = 8;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: decode/resolution inputs and hazard/RAS outputs of the pipeline controller.
interface pipe_ctrl_if #(parameter int PC_W = 16);
  logic id_valid;
  logic [3:0] id_rs1;
  logic [3:0] id_rs2;
  logic id_use_rs1;
  logic id_use_rs2;
  logic ex_valid;
  logic [15:0] ex_instr;
  logic [PC_W-1:0] ex_pc;
  logic ex_is_load;
  logic [3:0] ex_rd;
  logic branch;
  logic mem_busy;
  logic data_hazard;
  logic control_hazard;
  logic if_id_flush;
  logic id_ex_bubble;
  logic ret_valid;
  logic [PC_W-1:0] ret_pc;
  logic ras_ovf;
  logic ras_unf;
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_valid, ex_instr, ex_pc,
           ex_is_load, ex_rd, branch, mem_busy,
    input data_hazard, control_hazard, if_id_flush, id_ex_bubble, ret_valid, ret_pc,
          ras_ovf, ras_unf
  );
  modport slave (
    input id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_valid, ex_instr, ex_pc,
          ex_is_load, ex_rd, branch, mem_busy,
    output data_hazard, control_hazard, if_id_flush, id_ex_bubble, ret_valid, ret_pc,
           ras_ovf, ras_unf
  );
endinterface

// File: rtl/pipe_ctrl_ret_addr_stack.sv
// ret_addr_stack: circular return-address stack; a push when full overwrites the oldest entry.
module ret_addr_stack #(
  parameter int DEPTH = 8,
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[ptr - AW'(1)];
  always_ff @(posedge clk)
    if (push) mem[ptr] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + AW'(1);
      cnt <= full ? cnt : cnt + (AW+1)'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - AW'(1);
      cnt <= cnt - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: load-use/memory/redirect hazard sequencing plus RET target supply from the RAS.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int PC_W = 16
) (
  input logic clk,
  input logic rst_n,
  pipe_ctrl_if.slave bus
);
  logic [1:0] state, state_nx;
  logic [3:0] op;
  logic active, is_call, is_ret, taken_b, load_use, quiet, push, pop;
  logic full, empty, ovf, unf;
  logic [PC_W-1:0] dout, ret_q;
  assign op = bus.ex_instr[15:12];
  // MEM_WAIT with mem_busy low behaves exactly like RUN, so EX is re-evaluated that cycle
  always_comb begin
    active = state != S_RET_REDIR;
    is_call = bus.ex_valid && op == OP_CALL;
    is_ret = bus.ex_valid && op == OP_RET;
    taken_b = bus.ex_valid && op == OP_B && bus.branch;
    load_use = bus.ex_valid && bus.ex_is_load && bus.id_valid &&
               ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
    quiet = active && !bus.mem_busy;
    push = quiet && is_call;
    pop = quiet && is_ret;
    state_nx = !active ? S_RUN : bus.mem_busy ? S_MEM_WAIT : is_ret ? S_RET_REDIR : S_RUN;
  end
  assign bus.id_ex_bubble = quiet && !is_ret && !is_call && !taken_b && load_use;
  assign bus.data_hazard = (active && bus.mem_busy) || bus.id_ex_bubble;
  assign bus.control_hazard = !active || (quiet && (is_call || taken_b));
  assign bus.if_id_flush = !active;
  assign bus.ret_valid = !active;
  assign bus.ret_pc = ret_q;
  assign bus.ras_ovf = ovf;
  assign bus.ras_unf = unf;
  ret_addr_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(bus.ex_pc + PC_W'(2)),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RUN;
      ret_q <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop) ret_q <= empty ? '0 : dout;
      if (push && full) ovf <= 1'b1;
      if (pop && empty) unf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus with queued expectations checked by a negedge monitor.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  logic eo = 0;
  logic eu = 0;
  logic [15:0] prv = 16'h0;
  string nm_q[$];
  logic [22:0] exp_q[$];
  pipe_ctrl_if #(.PC_W(16)) b ();
  pipe_ctrl #(.RAS_DEPTH(8), .PC_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [22:0] e, a;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a = {b.data_hazard, b.control_hazard, b.if_id_flush, b.id_ex_bubble, b.ret_valid,
           b.ras_ovf, b.ras_unf, b.ret_pc};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got dh/ch/fl/bb/rv/ovf/unf=%b ret_pc=%h, expected %b ret_pc=%h",
                 n, a[22:16], a[15:0], e[22:16], e[15:0]);
      end
    end
  end
  initial begin
    #100000;
    checks++;
    errors++;
    $display("FAIL timeout: directed sequence did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  task automatic drive(logic ev, logic [3:0] op, logic [15:0] pc, logic ld, logic [3:0] rd,
                       logic br, logic mb);
    b.ex_valid = ev;
    b.ex_instr = {op, 12'h000};
    b.ex_pc = pc;
    b.ex_is_load = ld;
    b.ex_rd = rd;
    b.branch = br;
    b.mem_busy = mb;
  endtask
  task automatic id_in(logic v, logic [3:0] r1, logic [3:0] r2, logic u1, logic u2);
    b.id_valid = v;
    b.id_rs1 = r1;
    b.id_rs2 = r2;
    b.id_use_rs1 = u1;
    b.id_use_rs2 = u2;
  endtask
  task automatic idle();
    drive(0, 4'h0, 16'h0, 0, 4'h0, 0, 0);
    id_in(0, 4'h0, 4'h0, 0, 0);
  endtask
  task automatic chk(string nm, logic dh, logic ch, logic fl, logic bb, logic rv,
                     logic [15:0] rp);
    nm_q.push_back(nm);
    exp_q.push_back({dh, ch, fl, bb, rv, eo, eu, rp});
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [15:0] e3 [3];
    e3 = '{16'h0032, 16'h0022, 16'h0012};
    idle();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({b.data_hazard, b.control_hazard, b.if_id_flush, b.id_ex_bubble, b.ret_valid,
         b.ras_ovf, b.ras_unf, b.ret_pc} !== 23'h0) begin
      errors++;
      $display("FAIL reset_state: outputs not all 0 under reset (ret_pc=%h)", b.ret_pc);
    end
    chk("reset", 0, 0, 0, 0, 0, 16'h0);
    rst_n = 1;
    drive(1, 4'h0, 16'h0, 1, 4'd3, 0, 0);
    id_in(1, 4'd3, 4'd0, 1, 0);
    chk("load_use_rs1", 1, 0, 0, 1, 0, prv);
    idle();
    chk("load_use_clear", 0, 0, 0, 0, 0, prv);
    drive(1, 4'h0, 16'h0, 1, 4'd5, 0, 0);
    id_in(1, 4'd1, 4'd5, 0, 1);
    chk("load_use_rs2", 1, 0, 0, 1, 0, prv);
    id_in(1, 4'd5, 4'd1, 0, 1);
    chk("no_use_no_hazard", 0, 0, 0, 0, 0, prv);
    drive(0, 4'h0, 16'h0, 1, 4'd5, 0, 0);
    id_in(1, 4'd5, 4'd5, 1, 1);
    chk("ex_invalid", 0, 0, 0, 0, 0, prv);
    drive(1, OP_CALL, 16'h0120, 0, 4'd0, 0, 0);
    id_in(0, 4'd0, 4'd0, 0, 0);
    chk("call", 0, 1, 0, 0, 0, prv);
    drive(1, OP_B, 16'h0130, 0, 4'd0, 1, 0);
    chk("branch_taken", 0, 1, 0, 0, 0, prv);
    drive(1, OP_B, 16'h0130, 0, 4'd0, 0, 0);
    chk("branch_not_taken", 0, 0, 0, 0, 0, prv);
    drive(1, OP_RET, 16'h0140, 0, 4'd0, 0, 0);
    chk("ret_issue", 0, 0, 0, 0, 0, prv);
    idle();
    prv = 16'h0122;
    chk("ret_redir", 0, 1, 1, 0, 1, prv);
    chk("after_redir", 0, 0, 0, 0, 0, prv);
    for (int i = 1; i <= 3; i++) begin
      drive(1, OP_CALL, 16'(i * 16), 0, 4'd0, 0, 0);
      chk("nest_call", 0, 1, 0, 0, 0, prv);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, OP_RET, 16'h0, 0, 4'd0, 0, 0);
      chk("nest_ret", 0, 0, 0, 0, 0, prv);
      idle();
      prv = e3[i];
      chk("nest_redir", 0, 1, 1, 0, 1, prv);
    end
    for (int i = 0; i <= 8; i++) begin
      drive(1, OP_CALL, 16'h1000 + 16'(i * 16), 0, 4'd0, 0, 0);
      chk("ovf_call", 0, 1, 0, 0, 0, prv);
    end
    eo = 1;
    for (int i = 8; i >= 1; i--) begin
      drive(1, OP_RET, 16'h0, 0, 4'd0, 0, 0);
      chk("ras_ret", 0, 0, 0, 0, 0, prv);
      idle();
      prv = 16'h1002 + 16'(i * 16);
      chk("ras_redir", 0, 1, 1, 0, 1, prv);
    end
    drive(1, OP_RET, 16'h0, 0, 4'd0, 0, 0);
    chk("unf_ret", 0, 0, 0, 0, 0, prv);
    idle();
    eu = 1;
    prv = 16'h0;
    chk("unf_redir", 0, 1, 1, 0, 1, prv);
    drive(1, 4'h0, 16'h0, 1, 4'd7, 0, 1);
    id_in(1, 4'd7, 4'd0, 1, 0);
    chk("mb_over_lu", 1, 0, 0, 0, 0, prv);
    drive(1, 4'h0, 16'h0, 1, 4'd7, 0, 0);
    chk("lu_release", 1, 0, 0, 1, 0, prv);
    idle();
    chk("lu_release_clear", 0, 0, 0, 0, 0, prv);
    drive(1, OP_CALL, 16'h0200, 0, 4'd0, 0, 0);
    chk("call5", 0, 1, 0, 0, 0, prv);
    for (int i = 0; i < 3; i++) begin
      drive(1, OP_RET, 16'h0, 0, 4'd0, 0, 1);
      chk("mem_busy_ret", 1, 0, 0, 0, 0, prv);
    end
    drive(1, OP_RET, 16'h0, 0, 4'd0, 0, 0);
    chk("ret_release", 0, 0, 0, 0, 0, prv);
    idle();
    prv = 16'h0202;
    chk("mem_redir", 0, 1, 1, 0, 1, prv);
    drive(1, OP_CALL, 16'h0300, 0, 4'd0, 0, 0);
    chk("call6", 0, 1, 0, 0, 0, prv);
    drive(1, OP_RET, 16'h0, 0, 4'd0, 0, 0);
    chk("ret6", 0, 0, 0, 0, 0, prv);
    idle();
    rst_n = 0;
    prv = 16'h0302;
    chk("redir_in_rst", 0, 1, 1, 0, 1, prv);
    rst_n = 1;
    eo = 0;
    eu = 0;
    prv = 16'h0;
    chk("post_rst", 0, 0, 0, 0, 0, prv);
    drive(1, OP_RET, 16'h0, 0, 4'd0, 0, 0);
    chk("ret_after_rst", 0, 0, 0, 0, 0, prv);
    idle();
    eu = 1;
    chk("empty_after_rst", 0, 1, 1, 0, 1, prv);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
